snn_timestep_sched: RTL
=======================

Name: snn_timestep_sched

Overview:
Timestep scheduler for one SNN inference. It sequences per-timestep wordline drive, MUX/array settle, and the ADC conversion kick to the ADC controller, then waits for the neuron-input-valid strobe. It sits between the CSR/start logic and the input spike buffer, the WL driver and the ADC controller. It replaces software pacing of adc_kick_pulse.

Parameters:
TS_MAX, 16, maximum timesteps per inference; TS_W = $clog2(TS_MAX+1).
WL_SETTLE_CYCLES, 2, cycles wl_en is high before the kick (0 allowed).
TIMEOUT_CYCLES, 255, cycles after the kick to wait for neuron_in_valid (>=1).

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin an inference
abort  in  1  one-cycle request to cancel the running inference
cfg_timesteps  in  TS_W  number of timesteps, latched on accepted start
busy  out  1  inference in progress
done  out  1  one-cycle pulse when an inference ends (normally or by timeout)
err_timeout  out  1  sticky; set on timeout, cleared on next accepted start
ts_idx  out  TS_W  current timestep index, 0-based
frame_req  out  1  one-cycle pulse requesting the spike frame for ts_idx
frame_valid  in  1  input buffer has the frame on the WL bus
wl_en  out  1  enables the wordline drivers
adc_kick_pulse  out  1  one-cycle pulse to the ADC controller
neuron_in_valid  in  1  ADC controller finished all bitline samples

Behaviour:
- All outputs are registered. Reset (rst=1 at a posedge) clears every output to 0 and puts the FSM in IDLE. Reset mid-inference aborts silently with no done pulse.
- States: IDLE, FETCH, SETTLE, CONVERT, NEXT, FINISH.
- IDLE: start=1 and abort=0 at cycle N latches n_ts = min(cfg_timesteps, TS_MAX) and clears err_timeout.
  - If n_ts=0: done=1 at N+1 and busy stays 0.
  - Otherwise, at N+1: busy=1, ts_idx=0, frame_req=1 for 1 cycle, state FETCH.
- FETCH: wait for frame_valid. frame_valid is also honoured in the same cycle frame_req is high. frame_valid at cycle M gives wl_en=1 at M+1.
  - If WL_SETTLE_CYCLES>0: state SETTLE for WL_SETTLE_CYCLES cycles (M+1..M+S). adc_kick_pulse=1 at M+S+1, entering CONVERT.
  - If WL_SETTLE_CYCLES=0: adc_kick_pulse=1 at M+1, entering CONVERT directly.
- CONVERT: wl_en stays 1. The timeout counter loads TIMEOUT_CYCLES on the kick cycle and decrements each cycle.
  - neuron_in_valid at cycle V: wl_en=0 at V+1, state NEXT.
  - If the counter reaches 0 with no valid: err_timeout=1, wl_en=0, busy=0 and done=1 on the next cycle, then IDLE.
  - Valid and expiry in the same cycle: valid wins.
- NEXT (1 cycle, ~V+1):
  - If ts_idx == n_ts-1: FINISH, which gives done=1 and busy=0 at V+2, then IDLE. ts_idx holds its last value until the next start.
  - Else: ts_idx+1 and frame_req=1 at V+2, then FETCH.
- Exactly one adc_kick_pulse per timestep. wl_en is never high outside SETTLE/CONVERT.
- abort=1 in any non-IDLE state: next cycle IDLE with busy=0, wl_en=0, no done pulse; err_timeout unchanged. abort in IDLE is a no-op and suppresses a simultaneous start.
- start while busy is ignored.
- frame_valid outside FETCH and neuron_in_valid outside CONVERT are ignored.
- ts_idx arithmetic is TS_W bits unsigned and never exceeds TS_MAX-1 (assert).

Decomposition:
- Add sched_state_t, TS_MAX, SCHED_WL_SETTLE_CYCLES and SCHED_TIMEOUT_CYCLES to snn_soc_pkg.
- One sub-module, sched_timer: loadable down-counter with a zero flag. It is shared by SETTLE (load S-1) and CONVERT (load TIMEOUT_CYCLES); only one use is active at a time.

Test Plan:
- Nominal run: cfg_timesteps=3, S=2, frame_valid 1 cycle after each frame_req, neuron_in_valid 40 cycles after each kick. Expect 3 frame_req, 3 adc_kick_pulse, ts_idx 0,1,2, a single done, busy deasserted with done, err_timeout=0.
- Timing: S=2, frame_valid at cycle 10 gives wl_en at 11..kick-cycle. Expect adc_kick at 13 and wl_en=0 the cycle after neuron_in_valid. Repeat with S=0: kick at 11.
- Timeout: TIMEOUT_CYCLES=8, neuron_in_valid never arrives. Expect err_timeout=1 and done=1 at kick+9, busy=0, no further kicks. Then a new start clears err_timeout.
- Abort during CONVERT of ts 1 of 4: busy=0 and wl_en=0 next cycle, no done. A late neuron_in_valid is ignored.
- Edges, three separate runs: cfg_timesteps=0 gives done after 1 cycle with no kick; cfg_timesteps=31 is clamped to 16 kicks; start while busy is ignored and start+abort in IDLE does not start.
- Reset mid-SETTLE: rst=1 for one cycle clears all outputs, leaves the FSM in IDLE and gives no done pulse.

Source files
------------

// File: rtl/snn_soc_pkg.sv
// snn_soc_pkg: shared SoC constants and types.
// Holds the timestep scheduler state encoding and default timing.
package snn_soc_pkg;

  localparam int TS_MAX = 16;
  localparam int SCHED_WL_SETTLE_CYCLES = 2;
  localparam int SCHED_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_CONVERT,
    S_NEXT,
    S_FINISH
  } sched_state_t;

endpackage

// File: rtl/snn_timestep_sched_timer.sv
// sched_timer: loadable down-counter with a zero flag.
// Ports: load_i/val_i load, dec_i decrements (saturates at 0), zero_o flag.
module sched_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/snn_timestep_sched.sv
// snn_timestep_sched: per-timestep frame fetch, WL settle, ADC kick, wait.
// Ports: start/abort/cfg_timesteps control; busy/done/err_timeout/ts_idx
// status; frame_req/frame_valid, wl_en, adc_kick_pulse/neuron_in_valid.
module snn_timestep_sched #(
  parameter int TS_MAX = snn_soc_pkg::TS_MAX,
  parameter int WL_SETTLE_CYCLES = snn_soc_pkg::SCHED_WL_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = snn_soc_pkg::SCHED_TIMEOUT_CYCLES,
  localparam int TS_W = $clog2(TS_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TS_W-1:0] cfg_timesteps,
  output logic            busy,
  output logic            done,
  output logic            err_timeout,
  output logic [TS_W-1:0] ts_idx,
  output logic            frame_req,
  input  logic            frame_valid,
  output logic            wl_en,
  output logic            adc_kick_pulse,
  input  logic            neuron_in_valid
);
  import snn_soc_pkg::*;

  // Settle reuses the timeout counter: load S-1 so zero marks the last
  // settle cycle and the kick lands exactly S cycles after wl_en rises.
  localparam int SETTLE_LD =
    (WL_SETTLE_CYCLES > 0) ? WL_SETTLE_CYCLES - 1 : 0;
  localparam int TMR_MAX =
    (TIMEOUT_CYCLES > SETTLE_LD) ? TIMEOUT_CYCLES : SETTLE_LD;
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  sched_state_t    state_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [TS_W-1:0] ts_idx_q;
  logic [TS_W-1:0] n_ts_q;
  logic            frame_req_q;
  logic            wl_en_q;
  logic            kick_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [TS_W-1:0]  n_clamp;
  logic             ts_last;

  assign n_clamp = (cfg_timesteps > TS_W'(TS_MAX)) ?
                   TS_W'(TS_MAX) : cfg_timesteps;
  assign ts_last = (ts_idx_q == n_ts_q - 1'b1);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(TIMEOUT_CYCLES);
    tmr_dec  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        tmr_load = frame_valid;
        if (WL_SETTLE_CYCLES > 0) begin
          tmr_val = TMR_W'(SETTLE_LD);
        end
      end
      S_SETTLE: begin
        tmr_load = tmr_zero;
        tmr_dec  = 1'b1;
      end
      S_CONVERT: begin
        tmr_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  sched_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ts_idx_q    <= '0;
      n_ts_q      <= '0;
      frame_req_q <= 1'b0;
      wl_en_q     <= 1'b0;
      kick_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_req_q <= 1'b0;
      kick_q      <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        wl_en_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              err_q  <= 1'b0;
              n_ts_q <= n_clamp;
              if (n_clamp == '0) begin
                done_q <= 1'b1;
              end else begin
                busy_q      <= 1'b1;
                ts_idx_q    <= '0;
                frame_req_q <= 1'b1;
                state_q     <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (frame_valid) begin
              wl_en_q <= 1'b1;
              if (WL_SETTLE_CYCLES > 0) begin
                state_q <= S_SETTLE;
              end else begin
                state_q <= S_CONVERT;
                kick_q  <= 1'b1;
              end
            end
          end
          S_SETTLE: begin
            if (tmr_zero) begin
              state_q <= S_CONVERT;
              kick_q  <= 1'b1;
            end
          end
          S_CONVERT: begin
            // a valid arriving on the expiry cycle still counts
            if (neuron_in_valid) begin
              wl_en_q <= 1'b0;
              state_q <= S_NEXT;
            end else if (tmr_zero) begin
              err_q   <= 1'b1;
              wl_en_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          S_NEXT: begin
            if (ts_last) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              ts_idx_q    <= ts_idx_q + 1'b1;
              frame_req_q <= 1'b1;
              state_q     <= S_FETCH;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_timeout    = err_q;
  assign ts_idx         = ts_idx_q;
  assign frame_req      = frame_req_q;
  assign wl_en          = wl_en_q;
  assign adc_kick_pulse = kick_q;

  a_ts_range: assert property (
    @(posedge clk) disable iff (rst) ts_idx_q < TS_W'(TS_MAX)
  );

endmodule
